// File: rtl/movement_pulse_gen.sv
// Raw Go-board buttons -> synchronised, debounced, single-cycle movement pulses
// with auto-repeat on hold, one pulse per cycle, gated by the game-active flag.
module movement_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst_N,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    input  logic i_Game_Active,
    output logic o_Up_Mvt,
    output logic o_Down_Mvt,
    output logic o_Left_Mvt,
    output logic o_Right_Mvt
);

    localparam int NUM_SW  = 4;
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // Index 0..3 = Up, Down, Left, Right; lower index wins ties.
    logic [NUM_SW-1:0] raw;
    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    logic [NUM_SW-1:0]            sync1_q, sync2_q;
    logic [NUM_SW-1:0]            deb_q, deb_d, deb_prev_q;
    logic [NUM_SW-1:0][DEB_W-1:0] dcnt_q, dcnt_d;
    logic [NUM_SW-1:0]            arm_q, arm_d;
    logic [1:0]                   rdy_q, rdy_d;
    logic [NUM_SW-1:0]            rise;
    logic [NUM_SW-1:0]            pulse_q, pulse_d;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic [RPT_W-1:0] rlast;
    logic [1:0]       win;
    logic             any_rise;

    always_comb begin
        rdy_d = {rdy_q[0], 1'b1};
        for (int i = 0; i < NUM_SW; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
                end
            end
        end
        // A switch is armed only once it has been seen released after reset,
        // so a button held through reset never produces a pulse.
        arm_d = arm_q | ({NUM_SW{rdy_q[1]}} & ~sync2_q & ~deb_q);
        rise  = arm_q & deb_q & ~deb_prev_q;
    end

    always_comb begin
        win      = 2'd0;
        any_rise = |rise;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (rise[i]) win = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rcnt_d  = rcnt_q;
        pulse_d = '0;
        rlast   = (state_q == DELAY) ? DELAY_LAST : PERIOD_LAST;

        if (!i_Game_Active) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_rise) begin
                        pulse_d[win] = 1'b1;
                        owner_d      = win;
                        rcnt_d       = '0;
                        state_d      = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // Pre-emption first, then owner release, then repeat expiry.
                    if (any_rise) begin
                        pulse_d[win] = 1'b1;
                        owner_d      = win;
                        rcnt_d       = '0;
                        state_d      = DELAY;
                    end else if (!deb_q[owner_q]) begin
                        rcnt_d  = '0;
                        state_d = IDLE;
                    end else if (rcnt_q == rlast) begin
                        pulse_d[owner_q] = 1'b1;
                        rcnt_d           = '0;
                        state_d          = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            arm_q      <= '0;
            rdy_q      <= '0;
            pulse_q    <= '0;
            state_q    <= IDLE;
            owner_q    <= '0;
            rcnt_q     <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            arm_q      <= arm_d;
            rdy_q      <= rdy_d;
            pulse_q    <= pulse_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign o_Up_Mvt    = pulse_q[0];
    assign o_Down_Mvt  = pulse_q[1];
    assign o_Left_Mvt  = pulse_q[2];
    assign o_Right_Mvt = pulse_q[3];

endmodule

// File: tb/tb_movement_pulse_gen.sv
// Scoreboard bench for movement_pulse_gen: stimulus queues expected (cycle, direction)
// pulses, a negedge monitor pops and compares whenever any output is high.
module tb_movement_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       act = 1'b1;
    logic [3:0] sw = 4'b0;
    logic       up, dn, lf, rt;

    always #5 clk = ~clk;

    movement_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_N      (rst_n),
        .i_Switch_1   (sw[0]),
        .i_Switch_2   (sw[1]),
        .i_Switch_3   (sw[2]),
        .i_Switch_4   (sw[3]),
        .i_Game_Active(act),
        .o_Up_Mvt     (up),
        .o_Down_Mvt   (dn),
        .o_Left_Mvt   (lf),
        .o_Right_Mvt  (rt)
    );

    typedef struct {
        int cyc;
        int dir;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] mon_o;
    logic [3:0] mon_want;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_pulse(input int c, input int d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        q.push_back(e);
    endtask

    task automatic check_idle_out(input string name);
        tests++;
        if ({rt, lf, dn, up} != 4'b0) begin
            fails++;
            $display("FAIL %s: outputs=%b required=0000 at cycle %0d", name, {rt, lf, dn, up}, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon_o = {rt, lf, dn, up};
        if (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: no pulse seen, required dir %0d at cycle %0d", mon_e.dir, mon_e.cyc);
        end
        if (mon_o != 4'b0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: outputs=%b at cycle %0d, required none", mon_o, cyc);
            end else begin
                mon_e    = q.pop_front();
                mon_want = 4'b0001 << mon_e.dir;
                if (mon_o != mon_want || cyc != mon_e.cyc) begin
                    fails++;
                    $display("FAIL pulse: outputs=%b at cycle %0d, required %b at cycle %0d",
                             mon_o, cyc, mon_want, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;

        repeat (3) @(posedge clk);
        #1;
        check_idle_out("reset_state");
        #2 rst_n = 1'b1;
        step(8);

        // 1: Up held 10 cycles -> single pulse at +7, no repeat
        t0 = cyc;
        sw[0] = 1'b1;
        expect_pulse(t0 + 7, 0);
        wait_until(t0 + 10);
        sw[0] = 1'b0;
        wait_until(t0 + 40);

        // 2: 3-cycle glitches on Down never pass the debouncer
        for (int k = 0; k < 5; k++) begin
            sw[1] = 1'b1;
            step(3);
            sw[1] = 1'b0;
            step(3);
        end
        step(20);

        // 3: Right held -> first pulse, delayed repeat, periodic repeats
        t0 = cyc;
        sw[3] = 1'b1;
        expect_pulse(t0 + 7, 3);
        expect_pulse(t0 + 27, 3);
        expect_pulse(t0 + 35, 3);
        expect_pulse(t0 + 43, 3);
        expect_pulse(t0 + 51, 3);
        wait_until(t0 + 50);
        sw[3] = 1'b0;
        wait_until(t0 + 85);

        // 4: Up and Left together -> Up wins, Left dropped for good
        t0 = cyc;
        sw[0] = 1'b1;
        sw[2] = 1'b1;
        expect_pulse(t0 + 7, 0);
        wait_until(t0 + 12);
        sw[0] = 1'b0;
        wait_until(t0 + 45);
        sw[2] = 1'b0;
        wait_until(t0 + 60);

        // 5: Right pre-empts held Down; release lands on a repeat expiry
        t0 = cyc;
        sw[1] = 1'b1;
        expect_pulse(t0 + 7, 1);
        wait_until(t0 + 15);
        sw[3] = 1'b1;
        expect_pulse(t0 + 22, 3);
        expect_pulse(t0 + 42, 3);
        wait_until(t0 + 43);
        sw[1] = 1'b0;
        sw[3] = 1'b0;
        wait_until(t0 + 70);

        // 6a: Up pressed while inactive, then game activates -> nothing
        act = 1'b0;
        t0 = cyc;
        sw[0] = 1'b1;
        wait_until(t0 + 15);
        act = 1'b1;
        wait_until(t0 + 50);
        sw[0] = 1'b0;
        wait_until(t0 + 62);

        // 6b: reset during a repeat pulse, button still held afterwards
        t1 = cyc;
        sw[0] = 1'b1;
        expect_pulse(t1 + 7, 0);
        expect_pulse(t1 + 27, 0);
        wait_until(t1 + 35);
        #1 rst_n = 1'b0;
        #1 check_idle_out("async_reset_mid_repeat");
        step(3);
        #2 rst_n = 1'b1;
        step(50);
        sw[0] = 1'b0;
        step(20);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
